// File: rtl/bft_leaf_endpoint_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bft_leaf_endpoint_pkg
// Description : Shared constants and helpers for the BFT leaf endpoint.
//               Packet layout (MSB..LSB): {valid, dest_addr, payload}.
// Revision    : 1.0 - initial release
// ============================================================================
package bft_leaf_endpoint_pkg;

    // Width of the statistics counters and their saturation value
    localparam int          c_CNT_W   = 16;
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    // Gap counter width: wide enough to hold the gap value, never zero bits
    function automatic int f_gap_width(input int gap);
        int w;
        w = $clog2(gap + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bft_leaf_endpoint_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bft_sync_fifo
// Description : Synchronous first-word-fall-through FIFO. Pointers carry an
//               extra wrap bit so full and empty are distinguished without
//               an occupancy counter. A push on a full FIFO is accepted when
//               a pop happens on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module bft_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]        r_wr_ptr;
    logic [PTR_W:0]        r_rd_ptr;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign full     = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &&
                      (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign pop_data  = r_mem[r_rd_ptr[PTR_W-1:0]];

    // Pointer update; reset flushes contents by equalising the pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate them
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/bft_leaf_endpoint.sv
`default_nettype none
// ============================================================================
// Module      : bft_leaf_endpoint
// Description : Leaf endpoint of the butterfly-fat-tree deflection network.
//               TX: buffered valid/ready words injected as packets under a
//               minimum inter-injection gap. RX: packets absorbed every cycle
//               (the network cannot stall), buffered as a FWFT stream, with
//               sticky overflow and saturating drop/misroute statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module bft_leaf_endpoint
    import bft_leaf_endpoint_pkg::*;
#(
    parameter int NUM_LEAVES = 2,
    parameter int PAYLOAD_SZ = 1,
    parameter int ADDR       = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int INJ_GAP    = 0,
    localparam int ADDR_W    = $clog2(NUM_LEAVES),
    localparam int P_SZ      = 1 + ADDR_W + PAYLOAD_SZ
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [ADDR_W-1:0]     tx_dest,
    input  logic [PAYLOAD_SZ-1:0] tx_payload,
    output logic [P_SZ-1:0]       bus_o,
    input  logic [P_SZ-1:0]       bus_i,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [PAYLOAD_SZ-1:0] rx_payload,
    output logic                  rx_overflow,
    output logic [c_CNT_W-1:0]    drop_count,
    output logic [c_CNT_W-1:0]    misroute_count
);

    localparam int                TXW        = ADDR_W + PAYLOAD_SZ;
    localparam int                GAP_W      = f_gap_width(INJ_GAP);
    localparam logic [ADDR_W-1:0] c_OWN_ADDR = ADDR[ADDR_W-1:0];
    localparam logic [GAP_W-1:0]  c_GAP_LOAD = INJ_GAP[GAP_W-1:0];

    // ---------------------------------------------------------------- TX
    logic [TXW-1:0]    w_tx_head;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic              w_inject;
    logic [GAP_W-1:0]  r_gap_cnt;

    assign tx_ready = !w_tx_full;
    assign w_inject = !w_tx_empty && (r_gap_cnt == '0);

    bft_sync_fifo #(
        .DATA_WIDTH (TXW),
        .DEPTH      (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_valid && tx_ready),
        .push_data ({tx_dest, tx_payload}),
        .pop       (w_inject),
        .pop_data  (w_tx_head),
        .full      (w_tx_full),
        .empty     (w_tx_empty)
    );

    // Registered uplink: one formatted packet per injection, all-zero idle otherwise
    always_ff @(posedge clk) begin
        if (reset)         bus_o <= '0;
        else if (w_inject) bus_o <= {1'b1, w_tx_head};
        else               bus_o <= '0;
    end

    // Rate limiter: reload on injection, count down to zero between injections
    always_ff @(posedge clk) begin
        if (reset)                  r_gap_cnt <= '0;
        else if (w_inject)          r_gap_cnt <= c_GAP_LOAD;
        else if (r_gap_cnt != '0)   r_gap_cnt <= r_gap_cnt - GAP_W'(1);
    end

    // ---------------------------------------------------------------- RX
    logic                  w_bus_valid;
    logic [ADDR_W-1:0]     w_bus_dest;
    logic [PAYLOAD_SZ-1:0] w_bus_payload;
    logic                  w_for_me;
    logic                  w_misroute;
    logic                  w_rx_full;
    logic                  w_rx_empty;
    logic                  w_rx_pop;
    logic                  w_drop;

    assign w_bus_valid   = bus_i[P_SZ-1];
    assign w_bus_dest    = bus_i[P_SZ-2 -: ADDR_W];
    assign w_bus_payload = bus_i[PAYLOAD_SZ-1:0];
    assign w_for_me      = w_bus_valid && (w_bus_dest == c_OWN_ADDR);
    assign w_misroute    = w_bus_valid && (w_bus_dest != c_OWN_ADDR);
    assign rx_valid      = !w_rx_empty;
    assign w_rx_pop      = rx_valid && rx_ready;
    // Only a full FIFO with no simultaneous pop forces a drop
    assign w_drop        = w_for_me && w_rx_full && !w_rx_pop;

    bft_sync_fifo #(
        .DATA_WIDTH (PAYLOAD_SZ),
        .DEPTH      (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_for_me),
        .push_data (w_bus_payload),
        .pop       (w_rx_pop),
        .pop_data  (rx_payload),
        .full      (w_rx_full),
        .empty     (w_rx_empty)
    );

    // Overflow statistics: sticky flag plus saturating drop counter
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_overflow <= 1'b0;
            drop_count  <= '0;
        end else if (w_drop) begin
            rx_overflow <= 1'b1;
            if (drop_count != c_CNT_MAX) drop_count <= drop_count + 16'd1;
        end
    end

    // Misroute statistics: saturating count of valid packets for another leaf
    always_ff @(posedge clk) begin
        if (reset) begin
            misroute_count <= '0;
        end else if (w_misroute && (misroute_count != c_CNT_MAX)) begin
            misroute_count <= misroute_count + 16'd1;
        end
    end

endmodule
`default_nettype wire
